cycle_timing: RTL

- Instruction-cycle sequencer for the 4004 core. Sits upstream of the register file and decoder.
- Generates the eight one-hot phase strobes A1..X3 and SYNC.
- Latches the fetched instruction nibbles from DATA_I into opropa0 (first word) and opropa1 (second word).
- Tracks whether the current cycle is a first-word fetch, a second-word operand fetch, or a FIN indirect fetch.

---
 rtl/cycle_pkg.sv | 47 ++++
 rtl/cycle_phase_ring.sv | 64 ++++++
 rtl/cycle_timing.sv | 103 ++++++++++
 3 files changed

// File: rtl/cycle_pkg.sv
// Shared types and opcode decode for the 4004 instruction-cycle sequencer.
// Optional stop/stall support is enabled by defining CYCLE_TIMING_STOP_EN.
package cycle_pkg;

    typedef enum logic [3:0] {
        PH_IDLE,
        PH_A1,
        PH_A2,
        PH_A3,
        PH_M1,
        PH_M2,
        PH_X1,
        PH_X2,
        PH_X3
    } phase_t;

    typedef enum logic [1:0] {
        CT_FIRST,
        CT_OPERAND,
        CT_FIN
    } ctype_t;

    localparam logic [3:0] OPR_JCN     = 4'b0001;
    localparam logic [2:0] OPR_FIM_FIN = 3'b001;
    localparam logic [3:0] OPR_JUN     = 4'b0100;
    localparam logic [3:0] OPR_JMS     = 4'b0101;
    localparam logic [3:0] OPR_ISZ     = 4'b0111;

    // FIM shares OPR 0010 with SRC; only the even OPA form has an operand
    function automatic logic is_two_word(
        input logic [3:0] opr,
        input logic       opa0
    );
        logic fim;
        fim = (opr[3:1] == OPR_FIM_FIN) && !opr[0] && !opa0;
        return (opr == OPR_JCN) || (opr == OPR_JUN) ||
               (opr == OPR_JMS) || (opr == OPR_ISZ) || fim;
    endfunction

    function automatic logic is_fin(
        input logic [3:0] opr,
        input logic       opa0
    );
        return (opr[3:1] == OPR_FIM_FIN) && opr[0] && !opa0;
    endfunction

endpackage

// File: rtl/cycle_phase_ring.sv
// Nine-state phase counter (IDLE, A1..X3) with one-hot strobe decode.
// The hold input keeps the ring parked in X3 (stop/stall support).
module cycle_phase_ring
    import cycle_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    output phase_t     phase,
    output logic [7:0] strobe
);

    phase_t state;
    phase_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PH_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        strobe     = 8'h00;
        unique case (state)
            PH_IDLE: state_next = PH_A1;
            PH_A1: begin
                state_next = PH_A2;
                strobe     = 8'h80;
            end
            PH_A2: begin
                state_next = PH_A3;
                strobe     = 8'h40;
            end
            PH_A3: begin
                state_next = PH_M1;
                strobe     = 8'h20;
            end
            PH_M1: begin
                state_next = PH_M2;
                strobe     = 8'h10;
            end
            PH_M2: begin
                state_next = PH_X1;
                strobe     = 8'h08;
            end
            PH_X1: begin
                state_next = PH_X2;
                strobe     = 8'h04;
            end
            PH_X2: begin
                state_next = PH_X3;
                strobe     = 8'h02;
            end
            PH_X3: begin
                state_next = hold ? PH_X3 : PH_A1;
                strobe     = 8'h01;
            end
            default: state_next = PH_IDLE;
        endcase
    end

    assign phase = state;

endmodule

// File: rtl/cycle_timing.sv
// 4004 instruction-cycle sequencer: phase strobes, word latches, cycle type.
// Define CYCLE_TIMING_STOP_EN to add the stop_req stall input.
module cycle_timing
    import cycle_pkg::*;
(
`ifdef CYCLE_TIMING_STOP_EN
    input  logic       stop_req,
`endif
    input  logic       CLK,
    input  logic       RES,
    input  logic [3:0] DATA_I,
    output logic       SYNC,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       M1,
    output logic       M2,
    output logic       X1,
    output logic       X2,
    output logic       X3,
    output logic [7:0] opropa0,
    output logic [7:0] opropa1,
    output logic       second_word,
    output logic       fin_cycle,
    output logic       instr_valid
);

    phase_t     phase;
    logic [7:0] strobe;
    logic       hold;
    logic       advance;
    logic       two_word;
    logic       fin_op;
    ctype_t     ctype;
    ctype_t     ctype_next;

`ifdef CYCLE_TIMING_STOP_EN
    assign hold = stop_req;
`else
    assign hold = 1'b0;
`endif

    cycle_phase_ring u_ring (
        .clk    (CLK),
        .rst    (RES),
        .hold   (hold),
        .phase  (phase),
        .strobe (strobe)
    );

    assign {A1, A2, A3, M1, M2, X1, X2, X3} = strobe;
    assign SYNC = X3;

    assign two_word = is_two_word(opropa0[7:4], opropa0[0]);
    assign fin_op   = is_fin(opropa0[7:4], opropa0[0]);

    // type only moves on the X3->A1 edge, so a stall defers it
    assign advance = (phase == PH_X3) && !hold;

    always_comb begin
        ctype_next = ctype;
        if (advance) begin
            unique case (ctype)
                CT_FIRST: begin
                    if (two_word)    ctype_next = CT_OPERAND;
                    else if (fin_op) ctype_next = CT_FIN;
                    else             ctype_next = CT_FIRST;
                end
                default: ctype_next = CT_FIRST;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) ctype <= CT_FIRST;
        else     ctype <= ctype_next;
    end

    // FIN cycles route DATA_I to the register pair, so neither latch loads
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            opropa0 <= 8'h00;
            opropa1 <= 8'h00;
        end else begin
            if (ctype == CT_FIRST) begin
                if (phase == PH_M1) opropa0[7:4] <= DATA_I;
                if (phase == PH_M2) opropa0[3:0] <= DATA_I;
            end
            if (ctype == CT_OPERAND) begin
                if (phase == PH_M1) opropa1[7:4] <= DATA_I;
                if (phase == PH_M2) opropa1[3:0] <= DATA_I;
            end
        end
    end

    assign second_word = (ctype == CT_OPERAND);
    assign fin_cycle   = (ctype == CT_FIN);

    assign instr_valid = (phase == PH_X1) &&
                         (((ctype == CT_FIRST) && !two_word) ||
                          (ctype == CT_OPERAND));

endmodule
